// File: rtl/div_unit_if.sv
// Divider request/response bundle between the EX stage and div_unit.
// The pipeline side drives the master modport; the divider uses slave.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic               signed_div;
  logic               annul;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               busy;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_div, annul, dividend, divisor,
    input  busy, ready, result
  );

  modport slave (
    input  start, signed_div, annul, dividend, divisor,
    output busy, ready, result
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per clock, result {rem, quo}.
// Optional macro DIV_ZERO_FLAG_EN adds a div_zero output flagging divide-by-zero results.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  div_unit_if.slave    bus
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic         div_zero
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StOn, StDzero, StEnd} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    quo_q, quo_d;
  logic [WIDTH-1:0]    dvsr_q, dvsr_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic                ready_q, ready_d;
  logic [2*WIDTH-1:0]  result_q, result_d;

  // One restoring step; the W+1-bit difference's sign bit is the borrow.
  logic [WIDTH:0]      shifted;
  logic [WIDTH:0]      partial;
  logic                borrow;
  logic [WIDTH-1:0]    step_rem;
  logic [WIDTH-1:0]    step_quo;

  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    partial  = shifted - {1'b0, dvsr_q};
    borrow   = partial[WIDTH];
    step_rem = borrow ? shifted[WIDTH-1:0] : partial[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], ~borrow};
  end

`ifdef DIV_ZERO_FLAG_EN
  logic dz_q, dz_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    ready_d  = 1'b0;
    result_d = '0;
`ifdef DIV_ZERO_FLAG_EN
    dz_d     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.annul) begin
          if (bus.divisor == '0) begin
            state_d = StDzero;
            rem_d   = bus.dividend;
            quo_d   = '1;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
          end else begin
            state_d = StOn;
            cnt_d   = '0;
            rem_d   = '0;
            if (bus.signed_div) begin
              quo_d  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
              dvsr_d = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
              qneg_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              rneg_d = bus.dividend[WIDTH-1];
            end else begin
              quo_d  = bus.dividend;
              dvsr_d = bus.divisor;
              qneg_d = 1'b0;
              rneg_d = 1'b0;
            end
          end
        end
      end
      StOn: begin
        if (bus.annul) begin
          state_d = StIdle;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d  = StEnd;
            ready_d  = 1'b1;
            result_d = {rneg_q ? -step_rem : step_rem, qneg_q ? -step_quo : step_quo};
          end
        end
      end
      StDzero: begin
        if (bus.annul) begin
          state_d = StIdle;
        end else begin
          state_d  = StEnd;
          ready_d  = 1'b1;
          result_d = {rem_q, quo_q};
`ifdef DIV_ZERO_FLAG_EN
          dz_d     = 1'b1;
`endif
        end
      end
      StEnd: begin
        if (bus.annul || !bus.start) begin
          state_d = StIdle;
        end else begin
          ready_d  = 1'b1;
          result_d = result_q;
`ifdef DIV_ZERO_FLAG_EN
          dz_d     = dz_q;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dz_q <= 1'b0;
    end else begin
      dz_q <= dz_d;
    end
  end

  assign div_zero = dz_q;
`endif

  assign bus.busy   = (state_q == StOn) || (state_q == StDzero);
  assign bus.ready  = ready_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide-by-zero,
// annul and reset aborts, and result hold while start stays high.
module tb_div_unit;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus ();

`ifdef DIV_ZERO_FLAG_EN
  logic div_zero;
  div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus), .div_zero(div_zero));
`else
  div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request at a negedge, wait for ready, check result, optionally
  // hold start in END, then drop start and check outputs clear.
  task automatic do_op(input string tag, input logic sdiv, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int exp_lat, input int exp_busy,
                       input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                       input logic exp_dz, input int hold);
    int lat;
    int nbusy;
    logic [63:0] res;
    bus.start      = 1'b1;
    bus.signed_div = sdiv;
    bus.dividend   = a;
    bus.divisor    = b;
    lat   = 0;
    nbusy = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        // Operands are latched already; these must be ignored.
        bus.dividend   = 32'h1234_5678;
        bus.divisor    = 32'h0000_0003;
        bus.signed_div = ~sdiv;
      end
      if (bus.busy) nbusy++;
      if (bus.ready) break;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    if (exp_busy >= 0) chk({tag, ".busy_cycles"}, 64'(nbusy), 64'(exp_busy));
    res = bus.result;
    chk({tag, ".result"}, res, {exp_hi, exp_lo});
`ifdef DIV_ZERO_FLAG_EN
    chk({tag, ".div_zero"}, 64'(div_zero), 64'(exp_dz));
`else
    if (exp_dz) chk({tag, ".dz_quotient"}, 64'(bus.result[W-1:0]), 64'hFFFF_FFFF);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_ready"}, 64'(bus.ready), 64'd1);
      chk({tag, ".hold_result"}, bus.result, {exp_hi, exp_lo});
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, ".clear_ready"}, 64'(bus.ready), 64'd0);
    chk({tag, ".clear_result"}, bus.result, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk({tag, ".clear_dz"}, 64'(div_zero), 64'd0);
`endif
  endtask

  initial begin
    int seen;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.annul      = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset.busy", 64'(bus.busy), 64'd0);
    chk("reset.ready", 64'(bus.ready), 64'd0);
    chk("reset.result", bus.result, 64'd0);
    @(negedge clk);

    do_op("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 32, 32'h2, 32'hE, 1'b0, 5);
    do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    do_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, -1, 32'h0, 32'h8000_0000, 1'b0, 0);
    do_op("divu_5_0", 1'b0, 32'd5, 32'd0, 2, 1, 32'h5, 32'hFFFF_FFFF, 1'b1, 2);
    do_op("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 2, -1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 0);
    do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, -1, 32'h1, 32'hFFFF_FFFD, 1'b0, 0);
    do_op("div_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, -1, 32'hFFFF_FFFF, 32'h3, 1'b0, 0);
    do_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, -1, 32'h0, 32'hFFFF_FFFF, 1'b0, 0);
    do_op("divu_3_5", 1'b0, 32'd3, 32'd5, 33, -1, 32'h3, 32'h0, 1'b0, 0);
    do_op("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'h10, 33, -1, 32'hF, 32'h0FFF_FFFF, 1'b0, 0);

    // Annul 10 cycles into ON: back to IDLE next cycle, no result ever.
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd100;
    bus.divisor    = 32'd7;
    repeat (10) @(negedge clk);
    chk("annul.busy_before", 64'(bus.busy), 64'd1);
    bus.annul = 1'b1;
    @(negedge clk);
    bus.annul = 1'b0;
    bus.start = 1'b0;
    chk("annul.busy_after", 64'(bus.busy), 64'd0);
    chk("annul.ready_after", 64'(bus.ready), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready || bus.busy) seen++;
    end
    chk("annul.no_result", 64'(seen), 64'd0);
    do_op("divu_9_3", 1'b0, 32'd9, 32'd3, 33, 32, 32'h0, 32'h3, 1'b0, 0);

    // Synchronous reset in the middle of ON.
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd1000;
    bus.divisor    = 32'd9;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_mid.busy", 64'(bus.busy), 64'd0);
    chk("rst_mid.ready", 64'(bus.ready), 64'd0);
    chk("rst_mid.result", bus.result, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    do_op("divu_1000_9", 1'b0, 32'd1000, 32'd9, 33, 32, 32'h1, 32'd111, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
